// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: registered peripheral decoder for the MIPS data bus.
// Decodes a peripheral ID from addresses with bit 31 set. Runs a
// ready/wait handshake with the selected peripheral and stalls the CPU
// until the access completes. Unmapped IDs and peripherals that never
// answer end in a one-cycle bus error instead of a hung core.
//
// Handshake: while in ACCESS, ce_out[idx] is held high. The access
// completes on the first rising edge where ready_in[idx] is high;
// ready_in bits of other peripherals are ignored.
module periph_bus_ctrl #(
    parameter int                    NUM_PERIPH     = 4,
    parameter logic [NUM_PERIPH*4-1:0] PERIPH_IDS   = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                address,
    input  logic                       rw,
    input  logic                       ce,
    input  logic [31:0]                data_from_mips,
    input  logic [NUM_PERIPH*32-1:0]   data_from_periph,
    input  logic [NUM_PERIPH-1:0]      ready_in,
    output logic [15:0]                ce_out,
    output logic [15:0]                rw_out,
    output logic [3:0]                 address_reg,
    output logic [31:0]                data_to_periph,
    output logic [31:0]                data_to_mips,
    output logic                       stall,
    output logic                       bus_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [3:0]  idx;
    logic        rw_l;
    logic [15:0] cnt;

    logic        req;
    logic        hit;
    logic [3:0]  hit_idx;
    logic        sel_ready;
    logic [31:0] sel_data;

    assign req = ce & address[31];

    // CPU is held during the request cycle and for the whole access.
    assign stall = ((state == IDLE) && req) || (state == ACCESS);

    // ID decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
            if (address[11:8] == PERIPH_IDS[4*i +: 4]) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    // Select ready and read data of the latched peripheral only.
    always_comb begin
        sel_ready = 1'b0;
        sel_data  = 32'd0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (idx == 4'(i)) begin
                sel_ready = ready_in[i];
                sel_data  = data_from_periph[32*i +: 32];
            end
        end
    end

    // Access FSM with registered bus strobes and CPU-side results.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= 4'd0;
            rw_l           <= 1'b0;
            cnt            <= 16'd0;
            ce_out         <= 16'd0;
            rw_out         <= 16'd0;
            address_reg    <= 4'd0;
            data_to_periph <= 32'd0;
            data_to_mips   <= 32'd0;
            bus_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_to_mips <= 32'd0;
                    bus_error    <= 1'b0;
                    if (req) begin
                        if (hit) begin
                            idx            <= hit_idx;
                            rw_l           <= rw;
                            cnt            <= 16'd0;
                            ce_out         <= 16'd1 << hit_idx;
                            rw_out         <= rw ? (16'd1 << hit_idx) : 16'd0;
                            address_reg    <= address[7:4];
                            data_to_periph <= data_from_mips;
                            state          <= ACCESS;
                        end else begin
                            data_to_mips <= ERR_DATA;
                            bus_error    <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is tested first so it beats a same-cycle timeout.
                    if (sel_ready || (cnt == TIMEOUT_LAST)) begin
                        ce_out         <= 16'd0;
                        rw_out         <= 16'd0;
                        address_reg    <= 4'd0;
                        data_to_periph <= 32'd0;
                        state          <= DONE;
                        if (sel_ready) begin
                            data_to_mips <= rw_l ? 32'd0 : sel_data;
                            bus_error    <= 1'b0;
                        end else begin
                            data_to_mips <= ERR_DATA;
                            bus_error    <= 1'b1;
                        end
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    // A request seen here is not a new access.
                    data_to_mips <= 32'd0;
                    bus_error    <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Testbench for periph_bus_ctrl: directed and random accesses with a
// scoreboard of expected CPU-side results checked in the DONE cycle.
module tb_periph_bus_ctrl;

    localparam int          NP  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       address;
    logic              rw;
    logic              ce;
    logic [31:0]       data_from_mips;
    logic [NP*32-1:0]  data_from_periph;
    logic [NP-1:0]     ready_in;
    logic [15:0]       ce_out;
    logic [15:0]       rw_out;
    logic [3:0]        address_reg;
    logic [31:0]       data_to_periph;
    logic [31:0]       data_to_mips;
    logic              stall;
    logic              bus_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    periph_bus_ctrl #(
        .NUM_PERIPH     (NP),
        .PERIPH_IDS     ({4'h3, 4'h2, 4'h1, 4'h0}),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .address          (address),
        .rw               (rw),
        .ce               (ce),
        .data_from_mips   (data_from_mips),
        .data_from_periph (data_from_periph),
        .ready_in         (ready_in),
        .ce_out           (ce_out),
        .rw_out           (rw_out),
        .address_reg      (address_reg),
        .data_to_periph   (data_to_periph),
        .data_to_mips     (data_to_mips),
        .stall            (stall),
        .bus_error        (bus_error)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_ce_out"}, {16'd0, ce_out}, 32'd0);
        check({tag, "_rw_out"}, {16'd0, rw_out}, 32'd0);
        check({tag, "_addr_reg"}, {28'd0, address_reg}, 32'd0);
        check({tag, "_dtp"}, data_to_periph, 32'd0);
        check({tag, "_dtm"}, data_to_mips, 32'd0);
        check({tag, "_berr"}, {31'd0, bus_error}, 32'd0);
    endtask

    // Driver: called just after a rising edge; returns just after a rising edge.
    // pidx < 0 means unmapped; rdy_cyc is the ACCESS cycle (1-based) of ready, 0 = never.
    task automatic run_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                              input int pidx, input int rdy_cyc, input logic [31:0] rdata,
                              input logic [NP-1:0] stray, input int exp_stall);
        logic        err;
        logic [32:0] exp;
        logic [15:0] exp_ce;
        int          k;
        bit          done;
        err    = (pidx < 0) || (rdy_cyc == 0);
        exp_ce = (pidx < 0) ? 16'd0 : (16'd1 << pidx);
        exp_q.push_back({err, err ? ERR : (wr ? 32'd0 : rdata)});
        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            if (k == 0) begin
                ce = 1'b1; address = addr; rw = wr; data_from_mips = wdata; ready_in = '0;
            end else begin
                ce = 1'b0; address = $urandom; rw = ~wr; data_from_mips = $urandom;
                ready_in = stray;
                if (pidx >= 0 && k == rdy_cyc) ready_in[pidx] = 1'b1;
            end
            for (int i = 0; i < NP; i++) data_from_periph[32*i +: 32] = $urandom;
            if (pidx >= 0) data_from_periph[32*pidx +: 32] = rdata;
            @(negedge clock);
            if (stall) begin
                if (k == 0) begin
                    check("req_ce_out", {16'd0, ce_out}, 32'd0);
                end else begin
                    check("acc_ce_out", {16'd0, ce_out}, {16'd0, exp_ce});
                    check("acc_rw_out", {16'd0, rw_out}, {16'd0, wr ? exp_ce : 16'd0});
                    check("acc_addr_reg", {28'd0, address_reg}, {28'd0, addr[7:4]});
                    check("acc_dtp", data_to_periph, wdata);
                    check("acc_berr", {31'd0, bus_error}, 32'd0);
                end
                k++;
                @(posedge clock); #1;
            end else begin
                done = 1'b1;
            end
        end
        check("stall_cycles", k, exp_stall);
        exp = exp_q.pop_front();
        if (done) begin
            check("done_dtm", data_to_mips, exp[31:0]);
            check("done_berr", {31'd0, bus_error}, {31'd0, exp[32]});
            check("done_ce_out", {16'd0, ce_out}, 32'd0);
        end else begin
            check("stall_bound", 32'd0, 32'd1);
        end
        @(posedge clock); #1;
        ce = 1'b0; ready_in = '0;
        @(negedge clock);
        check_all_zero("post_idle");
        @(posedge clock); #1;
    endtask

    initial begin
        int id, rc, pidx, st;
        logic wr;
        logic [31:0] a;
        reset = 1'b1; address = '0; rw = 1'b0; ce = 1'b0; data_from_mips = '0;
        data_from_periph = '0; ready_in = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // read hit, ready on 3rd ACCESS cycle
        run_access(32'h8000_0210, 1'b0, 32'h0, 2, 3, 32'h1234_5678, '0, 4);
        // write hit, ready on 1st ACCESS cycle
        run_access(32'h8000_0030, 1'b1, 32'hA5A5_0001, 0, 1, 32'h5555_AAAA, '0, 2);
        // unmapped ID
        run_access(32'h8000_0F00, 1'b0, 32'h1, -1, 0, 32'h0, '0, 1);
        // timeout with no ready, then ready exactly on the last cycle
        run_access(32'h8000_0140, 1'b0, 32'h2, 1, 0, 32'h0BAD_0BAD, '0, 1 + TO);
        run_access(32'h8000_0140, 1'b0, 32'h3, 1, TO, 32'hCAFE_F00D, '0, 1 + TO);
        // stray ready on another peripheral must be ignored
        run_access(32'h8000_0220, 1'b0, 32'h4, 2, 2, 32'h0F0F_1234, 4'b0010, 3);

        // non-peripheral address: no stall, no strobes
        ce = 1'b1; address = 32'h0000_0210; rw = 1'b1;
        @(negedge clock);
        check("nonp_stall0", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("nonp_stall1", {31'd0, stall}, 32'd0);
        check("nonp_ce_out", {16'd0, ce_out}, 32'd0);
        @(posedge clock); #1;
        ce = 1'b0;

        // reset on the 2nd ACCESS cycle
        ce = 1'b1; address = 32'h8000_0110; rw = 1'b1; data_from_mips = 32'h7777_0000;
        @(negedge clock);
        check("rst_req_stall", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        ce = 1'b0;
        @(negedge clock);
        check("rst_acc1_ce", {16'd0, ce_out}, 32'h2);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_acc2_ce", {16'd0, ce_out}, 32'h2);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("rst_mid");
        @(posedge clock); #1;
        run_access(32'h8000_0350, 1'b0, 32'h5, 3, 2, 32'h8765_4321, '0, 3);

        // random accesses
        for (int n = 0; n < 12; n++) begin
            id   = $urandom_range(0, 5);
            rc   = $urandom_range(0, TO);
            wr   = 1'($urandom_range(0, 1));
            pidx = (id < NP) ? id : -1;
            st   = (pidx < 0) ? 1 : ((rc == 0) ? 1 + TO : 1 + rc);
            a    = {1'b1, 19'($urandom), 4'(id), 4'($urandom), 4'($urandom)};
            run_access(a, wr, $urandom, pidx, rc, $urandom, '0, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_bus_ctrl.md
Name: periph_bus_ctrl

Overview:
Registered successor to the combinational peripheral decoder on the MIPS monocycle data bus. It decodes a peripheral ID from addresses with bit 31 set across a parametrised number of peripherals. It runs a per-access ready/wait handshake and stalls the CPU until the access completes. Accesses to unmapped IDs, and peripherals that never answer, produce a bus error instead of hanging the core.

Parameters:
NUM_PERIPH, 4, number of attached peripherals, legal range 1..16
PERIPH_IDS, {4'h3,4'h2,4'h1,4'h0}, packed NUM_PERIPH*4-bit vector; slice i holds the 4-bit ID of peripheral i
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before abort, legal range 1..65535
ERR_DATA, 32'hDEAD_BEEF, read data returned on a bus error

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
address  input  32  CPU data address; [31]=peripheral space, [11:8]=peripheral ID, [7:4]=register index
rw  input  1  1=write, 0=read
ce  input  1  CPU data-bus enable
data_from_mips  input  32  CPU write data
data_from_periph  input  NUM_PERIPH*32  read data; slice i from peripheral i
ready_in  input  NUM_PERIPH  bit i: peripheral i completes the current access this cycle
ce_out  output  16  one-hot peripheral enable; bits >= NUM_PERIPH are always 0
rw_out  output  16  one-hot write strobe, set only together with the matching ce_out bit
address_reg  output  4  latched register index
data_to_periph  output  32  latched write data
data_to_mips  output  32  read data returned to the CPU
stall  output  1  holds the CPU PC and pipeline state
bus_error  output  1  one-cycle error flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Request: req = ce & address[31]. Match: lowest i with address[11:8] == PERIPH_IDS[4i+3:4i]; duplicate IDs resolve to the lowest index.
- FSM states: IDLE, ACCESS, DONE. Reset value is IDLE.
- IDLE:
  - stall = req, combinational.
  - req with a match: latch idx, rw, address[7:4] and data_from_mips; clear the timeout counter; go to ACCESS.
  - req with no match: set err; go to DONE.
  - No req: stay in IDLE.
- ACCESS:
  - ce_out[idx] = 1; rw_out[idx] = latched rw; address_reg and data_to_periph = latched values; stall = 1.
  - ready_in[idx] = 1: capture data_from_periph slice idx into the read register if the access is a read; clear err; go to DONE. ready_in bits other than idx are ignored.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: set err; go to DONE. Ready in the same cycle as timeout wins, so the access succeeds.
  - Minimum latency is 2 cycles of stall (request cycle plus one ACCESS cycle) when ready is asserted on the first ACCESS cycle.
- DONE:
  - stall = 0. The CPU commits the instruction on this edge.
  - data_to_mips = read register for a successful read, ERR_DATA on err, 0 for writes.
  - bus_error = err.
  - Next state is always IDLE. req seen in DONE is not a new access; back-to-back accesses restart from IDLE.
- Outside DONE: data_to_mips = 0 and bus_error = 0; never tri-stated.
- Outside ACCESS: ce_out, rw_out, address_reg and data_to_periph = 0.
- Timeout counter: 16 bits, saturating, active only in ACCESS.
- Reset mid-access: state returns to IDLE. All outputs, the latched fields, err and the counter clear on the same edge. The aborted access is not signalled.
- Changes to address, rw or data_from_mips during ACCESS are ignored; only the latched values are used.

Test Plan:
- Read hit: NUM_PERIPH=4, address=32'h8000_0210, rw=0, ce=1; ready_in[2] on the 3rd ACCESS cycle with data 32'h1234_5678 -> ce_out=16'h0004, rw_out=0, address_reg=1, stall high for 4 cycles; DONE gives data_to_mips=32'h1234_5678, bus_error=0.
- Write hit: address=32'h8000_0030, data_from_mips=32'hA5A5_0001, rw=1, ready_in[0] on the 1st ACCESS cycle -> ce_out=rw_out=16'h0001, data_to_periph=32'hA5A5_0001, address_reg=3, 2 stall cycles, data_to_mips=0.
- Unmapped ID: address=32'h8000_0F00 -> stall for 1 cycle, ce_out stays 0, DONE gives bus_error=1, data_to_mips=32'hDEAD_BEEF.
- Timeout: TIMEOUT_CYCLES=8, read of ID 1, no ready -> exactly 8 ACCESS cycles, then DONE with bus_error=1 and ERR_DATA. Repeat with ready arriving on the 8th cycle -> success, no error.
- Reset mid-access: assert reset on the 2nd ACCESS cycle -> next cycle IDLE with stall=0, ce_out=0 and all outputs 0; a fresh request then completes normally.
- Non-peripheral and stray ready: address[31]=0 with ce=1 -> no stall, no strobes. ready_in[1] pulsed during an access to ID 2 -> no effect.
